sync_fifo_param: RTL and testbench

//  Parametrised single-clock FIFO; successor to the fixed 4-bit tile FIFO. Generalises data width
//  and depth, adds occupancy count, programmable almost-full/almost-empty, selectable

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_ram_2p.sv | 25 ++
 rtl/sync_fifo_param.sv | 137 +++++++++++++
 tb/tb_sync_fifo_param.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared widths and read-mode constants for the parametrised FIFO
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Pointers carry one extra wrap bit above the address bits
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Occupancy must represent 0..DEPTH inclusive
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// rtl/fifo_ram_2p.sv - DEPTH x DATA_W register array, sync write, async read
module fifo_ram_2p #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr_i,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr_i,
    output logic [DATA_W-1:0]          rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage is deliberately not reset; the pointers define what is valid
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with flags, count and sticky errors
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [cnt_w(DEPTH)-1:0]       count,
    output logic                          overflow,
    output logic                          underflow,
    input  logic                          clr_err
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ptr_w(DEPTH);
    localparam int CNT_W  = cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] AF_C = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C = CNT_W'(AE_LEVEL);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d, empty_q, empty_d;
    logic              af_q, af_d, ae_q, ae_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              wr_acc, rd_acc;
    logic [DATA_W-1:0] ram_rdata;

    // Accept decisions, next pointers, next count and next flags from pre-edge state
    always_comb begin
        wr_acc   = wr_en & ~full_q;
        rd_acc   = rd_en & ~empty_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_acc);
        rd_ptr_d = rd_ptr_q + PTR_W'(rd_acc);
        count_d  = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d  = (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]) &&
                  (wr_ptr_d[PTR_W-1] != rd_ptr_d[PTR_W-1]);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);
        // A new error in the same cycle as clr_err keeps the flag set
        ovf_d   = (wr_en & full_q)  ? 1'b1 : (clr_err ? 1'b0 : ovf_q);
        unf_d   = (rd_en & empty_q) ? 1'b1 : (clr_err ? 1'b0 : unf_q);
    end

    // Pointer, count and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Write is suppressed while reset is held so no partial write lands
    fifo_ram_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_acc & ~rst),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (ram_rdata)
    );

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            // Head word shown directly; forced to zero while empty so stale storage never leaks
            assign rd_data  = empty_q ? '0 : ram_rdata;
            assign rd_valid = ~empty_q;
        end else begin : g_std
            logic [DATA_W-1:0] rd_data_q;
            logic              rd_valid_q;

            // Capture the popped head word; hold it until the next accepted read
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) begin
                        rd_data_q <= ram_rdata;
                    end
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - self-checking bench for sync_fifo_param in both read modes
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en = 1'b0;
    logic [3:0] wr_data = 4'h0;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;

    logic [3:0] s_rd_data, f_rd_data;
    logic       s_rd_valid, f_rd_valid;
    logic       s_full, f_full, s_empty, f_empty;
    logic       s_af, f_af, s_ae, f_ae;
    logic [3:0] s_count, f_count;
    logic       s_ovf, f_ovf, s_unf, f_unf;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(4), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf), .clr_err(clr_err)
    );

    sync_fifo_param #(.DATA_W(4), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf), .clr_err(clr_err)
    );

    // Behavioural model: a queue of words plus sticky error bits
    logic [3:0] mq[$];
    bit         m_ovf = 0, m_unf = 0, m_rv = 0;
    logic [3:0] m_rd = 4'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_ovf = 0; m_unf = 0; m_rv = 0; m_rd = 4'h0;
        end else begin
            bit wa, ra;
            wa = wr_en && (mq.size() < 8);
            ra = rd_en && (mq.size() > 0);
            if (wr_en && mq.size() == 8)      m_ovf = 1;
            else if (clr_err)                 m_ovf = 0;
            if (rd_en && mq.size() == 0)      m_unf = 1;
            else if (clr_err)                 m_unf = 0;
            m_rv = ra;
            if (ra) m_rd = mq.pop_front();
            if (wa) mq.push_back(wr_data);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every negedge: both instances against the model
    always @(negedge clk) begin
        int n;
        n = mq.size();
        chk("std.count",  32'(s_count),    32'(n));
        chk("std.empty",  32'(s_empty),    32'(n == 0));
        chk("std.full",   32'(s_full),     32'(n == 8));
        chk("std.af",     32'(s_af),       32'(n >= 6));
        chk("std.ae",     32'(s_ae),       32'(n <= 2));
        chk("std.ovf",    32'(s_ovf),      32'(m_ovf));
        chk("std.unf",    32'(s_unf),      32'(m_unf));
        chk("std.rvalid", 32'(s_rd_valid), 32'(m_rv));
        chk("std.rdata",  32'(s_rd_data),  32'(m_rd));
        chk("fwft.count", 32'(f_count),    32'(n));
        chk("fwft.full",  32'(f_full),     32'(n == 8));
        chk("fwft.ovf",   32'(f_ovf),      32'(m_ovf));
        chk("fwft.unf",   32'(f_unf),      32'(m_unf));
        chk("fwft.rvalid",32'(f_rd_valid), 32'(n > 0));
        chk("fwft.rdata", 32'(f_rd_data),  (n > 0) ? 32'(mq[0]) : 32'h0);
    end

    task automatic cyc(input bit w, input logic [3:0] d, input bit r, input bit c);
        wr_en = w; wr_data = d; rd_en = r; clr_err = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.empty", 32'(s_empty), 32'h1);
        chk("reset.ae",    32'(s_ae),    32'h1);
        chk("reset.rdata", 32'(s_rd_data), 32'h0);
        rst = 1'b0;

        // 1: single word through registered read
        cyc(1, 4'hA, 0, 0);
        cyc(0, 4'h0, 1, 0);
        chk("t1.rdata",  32'(s_rd_data),  32'hA);
        chk("t1.rvalid", 32'(s_rd_valid), 32'h1);
        chk("t1.empty",  32'(s_empty),    32'h1);
        chk("t1.count",  32'(s_count),    32'h0);
        cyc(0, 4'h0, 0, 0);
        chk("t1.rvalid_drop", 32'(s_rd_valid), 32'h0);

        // 2: fill, overflow attempt, drain in order
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 4'(i), 0, 0);
            chk("t2.af", 32'(s_af), 32'(i >= 6));
        end
        chk("t2.full",  32'(s_full),  32'h1);
        chk("t2.count", 32'(s_count), 32'h8);
        cyc(1, 4'hF, 0, 0);
        chk("t2.ovf",   32'(s_ovf),   32'h1);
        chk("t2.count9",32'(s_count), 32'h8);
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 4'h0, 1, 0);
            chk("t2.drain", 32'(s_rd_data), 32'(i));
        end
        chk("t2.empty", 32'(s_empty), 32'h1);

        // 3: underflow and clear priority
        cyc(0, 4'h0, 0, 1);
        cyc(0, 4'h0, 1, 0);
        chk("t3.unf",   32'(s_unf),   32'h1);
        chk("t3.count", 32'(s_count), 32'h0);
        cyc(0, 4'h0, 0, 1);
        chk("t3.clr",   32'(s_unf),   32'h0);
        cyc(0, 4'h0, 1, 1);
        chk("t3.err_wins", 32'(s_unf), 32'h1);
        cyc(0, 4'h0, 0, 1);

        // 4: wr+rd at full and mid-level, then mixed traffic across pointer wrap
        for (int i = 1; i <= 8; i++) cyc(1, 4'(i), 0, 0);
        cyc(1, 4'hC, 1, 0);
        chk("t4.pop",   32'(s_rd_data), 32'h1);
        chk("t4.ovf",   32'(s_ovf),     32'h1);
        chk("t4.count", 32'(s_count),   32'h7);
        repeat (3) cyc(0, 4'h0, 1, 0);
        chk("t4.at4",   32'(s_count),   32'h4);
        cyc(1, 4'hD, 1, 0);
        chk("t4.same",  32'(s_count),   32'h4);
        chk("t4.rd5",   32'(s_rd_data), 32'h5);
        for (int i = 0; i < 20; i++) begin
            cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 0);
        end
        repeat (9) cyc(0, 4'h0, 1, 0);
        cyc(0, 4'h0, 0, 1);

        // 5: FWFT visibility and pop
        cyc(1, 4'h5, 0, 0);
        chk("t5.rdata",  32'(f_rd_data),  32'h5);
        chk("t5.rvalid", 32'(f_rd_valid), 32'h1);
        cyc(0, 4'h0, 1, 0);
        chk("t5.empty",  32'(f_empty),    32'h1);
        chk("t5.rvalid0",32'(f_rd_valid), 32'h0);

        // 6: asynchronous reset mid-burst
        for (int i = 0; i < 5; i++) cyc(1, 4'(i + 7), 0, 0);
        cyc(1, 4'h9, 1, 0);
        chk("t6.count5", 32'(s_count), 32'h5);
        rst = 1'b1;
        #1;
        chk("t6.count",  32'(s_count),    32'h0);
        chk("t6.empty",  32'(s_empty),    32'h1);
        chk("t6.rvalid", 32'(s_rd_valid), 32'h0);
        chk("t6.rdata",  32'(s_rd_data),  32'h0);
        chk("t6.frdata", 32'(f_rd_data),  32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1, 4'h3, 0, 0);
        cyc(0, 4'h0, 1, 0);
        chk("t6.rd3",    32'(s_rd_data),  32'h3);
        cyc(0, 4'h0, 0, 0);
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
